// File: rtl/directive_chk_pkg.sv
// Shared types and constants for the conditional-directive nesting checker:
// error codes, FSM states, keyword identifiers and the ASCII values they use.
package directive_chk_pkg;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_INDENT    = 3'd1,
    ERR_SAMELINE  = 3'd2,
    ERR_UNDERFLOW = 3'd3,
    ERR_OVERFLOW  = 3'd4,
    ERR_UNCLOSED  = 3'd5
  } err_code_e;

  typedef enum logic [1:0] {
    ST_LSTART  = 2'd0,  // counting leading spaces of a line
    ST_BODY    = 2'd1,  // rest of the line
    ST_KEYWORD = 2'd2,  // collecting a directive name after a backtick
    ST_FLUSH   = 2'd3   // end-of-file check
  } state_e;

  typedef enum logic [2:0] {
    KW_NONE   = 3'd0,
    KW_IFDEF  = 3'd1,
    KW_IFNDEF = 3'd2,
    KW_ELSIF  = 3'd3,
    KW_ELSE   = 3'd4,
    KW_ENDIF  = 3'd5
  } kw_e;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_NEWLINE  = 8'h0A;
  localparam logic [7:0] CH_BACKTICK = 8'h60;

  // Longest name worth keeping; a longer name is marked with length 7.
  localparam int KW_MAX_LEN = 6;

  // Keyword buffer is a shift register: first character ends up in the
  // most significant occupied byte, unused upper bytes stay zero.
  localparam logic [47:0] STR_IFDEF  = {8'h00, 8'h69, 8'h66, 8'h64, 8'h65, 8'h66};
  localparam logic [47:0] STR_IFNDEF = {8'h69, 8'h66, 8'h6E, 8'h64, 8'h65, 8'h66};
  localparam logic [47:0] STR_ELSIF  = {8'h00, 8'h65, 8'h6C, 8'h73, 8'h69, 8'h66};
  localparam logic [47:0] STR_ELSE   = {8'h00, 8'h00, 8'h65, 8'h6C, 8'h73, 8'h65};
  localparam logic [47:0] STR_ENDIF  = {8'h00, 8'h65, 8'h6E, 8'h64, 8'h69, 8'h66};

  // Identifier character class [A-Za-z0-9_].
  function automatic logic is_ident(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) ||
           ((c >= 8'h61) && (c <= 8'h7A)) ||
           ((c >= 8'h30) && (c <= 8'h39)) ||
           (c == 8'h5F);
  endfunction

endpackage

// File: rtl/directive_kw_match.sv
// Maps the collected directive name (buffer + length) to a keyword id.
// Pure decode; all sequencing lives in directive_nest_checker.
module directive_kw_match
  import directive_chk_pkg::*;
(
  input  logic [47:0] kw_buf,
  input  logic [2:0]  kw_len,
  output kw_e         kw
);

  // Compare against the recognized names of the matching length.
  always_comb begin
    kw = KW_NONE;
    case (kw_len)
      3'd4: begin
        if (kw_buf == STR_ELSE) begin
          kw = KW_ELSE;
        end else begin
          kw = KW_NONE;
        end
      end
      3'd5: begin
        if (kw_buf == STR_IFDEF) begin
          kw = KW_IFDEF;
        end else if (kw_buf == STR_ELSIF) begin
          kw = KW_ELSIF;
        end else if (kw_buf == STR_ENDIF) begin
          kw = KW_ENDIF;
        end else begin
          kw = KW_NONE;
        end
      end
      3'd6: begin
        if (kw_buf == STR_IFNDEF) begin
          kw = KW_IFNDEF;
        end else begin
          kw = KW_NONE;
        end
      end
      default: kw = KW_NONE;
    endcase
  end

endmodule

// File: rtl/directive_nest_checker.sv
// Streaming checker for `ifdef/`ifndef/`elsif/`else/`endif nesting in a
// source file presented one character per transfer. Reports indentation,
// same-line, underflow, overflow and unclosed-at-EOF errors as a
// registered, back-pressured error record.
module directive_nest_checker
  import directive_chk_pkg::*;
#(
  parameter int DEPTH_MAX = 8,
  parameter int LINE_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     in_char,
  input  logic                           in_last,
  output logic                           err_valid,
  input  logic                           err_ready,
  output logic [2:0]                     err_code,
  output logic [LINE_W-1:0]              err_line,
  output logic [$clog2(DEPTH_MAX+1)-1:0] depth,
  output logic                           done
);

  localparam int DW = $clog2(DEPTH_MAX + 1);
  // Indent counter is wide enough that its saturation value never equals
  // a legal expected indent (2*DEPTH_MAX).
  localparam int IW = DW + 2;

  localparam logic [DW-1:0]     DEPTH_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0]     DEPTH_ONE  = DW'(1);
  localparam logic [DW-1:0]     DEPTH_TOP  = DW'(DEPTH_MAX);
  localparam logic [IW-1:0]     INDENT_ONE = IW'(1);
  localparam logic [IW-1:0]     INDENT_SAT = {IW{1'b1}};
  localparam logic [LINE_W-1:0] LINE_ONE   = LINE_W'(1);
  localparam logic [LINE_W-1:0] LINE_SAT   = {LINE_W{1'b1}};
  localparam logic [2:0]        LEN_CAP    = 3'(KW_MAX_LEN);

  // Registered state
  state_e            state_r;
  logic [IW-1:0]     indent_r;
  logic [DW-1:0]     depth_r;
  logic [LINE_W-1:0] line_r;
  logic              at_start_r;
  logic              cond_seen_r;
  logic [47:0]       kw_buf_r;
  logic [2:0]        kw_len_r;
  logic              unclosed_r;
  logic              err_valid_r;
  logic [2:0]        err_code_r;
  logic [LINE_W-1:0] err_line_r;
  logic              done_r;

  // Combinational helpers
  logic              xfer_s;
  logic              char_ident_s;
  logic [47:0]       cand_buf_s;
  logic [2:0]        cand_len_s;
  kw_e               kw_s;
  logic              kw_end_s;
  logic              is_open_s;
  logic              is_close_s;
  logic [IW-1:0]     exp_indent_s;
  err_code_e         new_err_s;
  logic [LINE_W-1:0] line_inc_s;
  logic [IW-1:0]     indent_inc_s;

  // Next-state values
  state_e            char_state_s;
  state_e            state_s;
  logic [IW-1:0]     indent_s;
  logic [DW-1:0]     depth_s;
  logic [LINE_W-1:0] line_s;
  logic              at_start_s;
  logic              cond_seen_s;
  logic [47:0]       kw_buf_s;
  logic [2:0]        kw_len_s;

  assign in_ready     = !(err_valid_r && !err_ready) && (state_r != ST_FLUSH);
  assign xfer_s       = in_valid && in_ready;
  assign char_ident_s = is_ident(in_char);
  assign line_inc_s   = (line_r == LINE_SAT) ? line_r : (line_r + LINE_ONE);
  assign indent_inc_s = (indent_r == INDENT_SAT) ? indent_r : (indent_r + INDENT_ONE);

  assign err_valid = err_valid_r;
  assign err_code  = err_code_r;
  assign err_line  = err_line_r;
  assign depth     = depth_r;
  assign done      = done_r;

  // Candidate keyword buffer including the current character when it extends
  // the name; lets a keyword ending on the in_last character still match.
  always_comb begin
    cand_buf_s = kw_buf_r;
    cand_len_s = kw_len_r;
    if ((state_r == ST_KEYWORD) && char_ident_s) begin
      if (kw_len_r < LEN_CAP) begin
        cand_buf_s = {kw_buf_r[39:0], in_char};
        cand_len_s = kw_len_r + 3'd1;
      end else begin
        cand_buf_s = kw_buf_r;
        cand_len_s = 3'd7;
      end
    end else begin
      cand_buf_s = kw_buf_r;
      cand_len_s = kw_len_r;
    end
  end

  directive_kw_match u_kw_match (
    .kw_buf (cand_buf_s),
    .kw_len (cand_len_s),
    .kw     (kw_s)
  );

  assign kw_end_s   = xfer_s && (state_r == ST_KEYWORD) && (!char_ident_s || in_last);
  assign is_open_s  = (kw_s == KW_IFDEF) || (kw_s == KW_IFNDEF);
  assign is_close_s = (kw_s == KW_ELSIF) || (kw_s == KW_ELSE) || (kw_s == KW_ENDIF);

  // Classify a terminating directive; at most one error, highest priority wins.
  always_comb begin
    if (is_open_s) begin
      exp_indent_s = {1'b0, depth_r, 1'b0};
    end else begin
      exp_indent_s = {1'b0, depth_r - DEPTH_ONE, 1'b0};
    end
    new_err_s = ERR_NONE;
    if (kw_end_s && is_close_s && (depth_r == DEPTH_ZERO)) begin
      new_err_s = ERR_UNDERFLOW;
    end else if (kw_end_s && is_open_s && (depth_r == DEPTH_TOP)) begin
      new_err_s = ERR_OVERFLOW;
    end else if (kw_end_s && (is_open_s || is_close_s) && cond_seen_r) begin
      new_err_s = ERR_SAMELINE;
    end else if (kw_end_s && (is_open_s || is_close_s) && at_start_r &&
                 (indent_r != exp_indent_s)) begin
      new_err_s = ERR_INDENT;
    end else begin
      new_err_s = ERR_NONE;
    end
  end

  // Per-character next-state: keyword effects first, then the character
  // itself (so a newline terminator clears the per-line flag afterwards).
  always_comb begin
    char_state_s = state_r;
    indent_s     = indent_r;
    depth_s      = depth_r;
    line_s       = line_r;
    at_start_s   = at_start_r;
    cond_seen_s  = cond_seen_r;
    kw_buf_s     = kw_buf_r;
    kw_len_s     = kw_len_r;
    if (xfer_s) begin
      if (kw_end_s && is_open_s) begin
        cond_seen_s = 1'b1;
        depth_s     = (depth_r == DEPTH_TOP) ? depth_r : (depth_r + DEPTH_ONE);
      end else if (kw_end_s && is_close_s) begin
        cond_seen_s = 1'b1;
        if ((kw_s == KW_ENDIF) && (depth_r != DEPTH_ZERO)) begin
          depth_s = depth_r - DEPTH_ONE;
        end else begin
          depth_s = depth_r;
        end
      end else begin
        cond_seen_s = cond_seen_r;
      end

      if (state_r == ST_LSTART) begin
        if (in_char == CH_SPACE) begin
          indent_s = indent_inc_s;
        end else if (in_char == CH_BACKTICK) begin
          char_state_s = ST_KEYWORD;
          at_start_s   = 1'b1;
          kw_buf_s     = 48'd0;
          kw_len_s     = 3'd0;
        end else if (in_char == CH_NEWLINE) begin
          indent_s    = {IW{1'b0}};
          cond_seen_s = 1'b0;
          line_s      = line_inc_s;
        end else begin
          char_state_s = ST_BODY;
        end
      end else if ((state_r == ST_KEYWORD) && char_ident_s) begin
        kw_buf_s = cand_buf_s;
        kw_len_s = cand_len_s;
      end else begin
        // BODY, or the terminator of a keyword handled as BODY
        if (in_char == CH_BACKTICK) begin
          char_state_s = ST_KEYWORD;
          at_start_s   = 1'b0;
          kw_buf_s     = 48'd0;
          kw_len_s     = 3'd0;
        end else if (in_char == CH_NEWLINE) begin
          char_state_s = ST_LSTART;
          indent_s     = {IW{1'b0}};
          cond_seen_s  = 1'b0;
          line_s       = line_inc_s;
        end else begin
          char_state_s = ST_BODY;
        end
      end
    end else begin
      char_state_s = state_r;
    end
    state_s = (xfer_s && in_last) ? ST_FLUSH : char_state_s;
  end

  // State, counters and the error record; FLUSH drains errors then resets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_LSTART;
      indent_r    <= {IW{1'b0}};
      depth_r     <= DEPTH_ZERO;
      line_r      <= LINE_ONE;
      at_start_r  <= 1'b0;
      cond_seen_r <= 1'b0;
      kw_buf_r    <= 48'd0;
      kw_len_r    <= 3'd0;
      unclosed_r  <= 1'b0;
      err_valid_r <= 1'b0;
      err_code_r  <= ERR_NONE;
      err_line_r  <= {LINE_W{1'b0}};
      done_r      <= 1'b0;
    end else if (state_r == ST_FLUSH) begin
      done_r <= 1'b0;
      if (err_valid_r && !err_ready) begin
        err_valid_r <= 1'b1;
      end else if (!unclosed_r && (depth_r != DEPTH_ZERO)) begin
        err_valid_r <= 1'b1;
        err_code_r  <= ERR_UNCLOSED;
        err_line_r  <= line_r;
        unclosed_r  <= 1'b1;
      end else begin
        state_r     <= ST_LSTART;
        indent_r    <= {IW{1'b0}};
        depth_r     <= DEPTH_ZERO;
        line_r      <= LINE_ONE;
        at_start_r  <= 1'b0;
        cond_seen_r <= 1'b0;
        kw_buf_r    <= 48'd0;
        kw_len_r    <= 3'd0;
        unclosed_r  <= 1'b0;
        err_valid_r <= 1'b0;
        err_code_r  <= ERR_NONE;
        err_line_r  <= {LINE_W{1'b0}};
        done_r      <= 1'b1;
      end
    end else begin
      done_r      <= 1'b0;
      state_r     <= state_s;
      indent_r    <= indent_s;
      depth_r     <= depth_s;
      line_r      <= line_s;
      at_start_r  <= at_start_s;
      cond_seen_r <= cond_seen_s;
      kw_buf_r    <= kw_buf_s;
      kw_len_r    <= kw_len_s;
      if (new_err_s != ERR_NONE) begin
        err_valid_r <= 1'b1;
        err_code_r  <= new_err_s;
        err_line_r  <= line_r;
      end else if (err_ready) begin
        err_valid_r <= 1'b0;
      end else begin
        err_valid_r <= err_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_directive_nest_checker.sv
// Directed bench for directive_nest_checker: feeds small source files and
// checks error records, depth and the done pulse against hand-computed values.
module tb_directive_nest_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        in_last;
  logic        err_valid;
  logic        err_ready;
  logic [2:0]  err_code;
  logic [15:0] err_line;
  logic [3:0]  depth;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [2:0]  rec_code [$];
  logic [15:0] rec_line [$];
  int          done_cnt = 0;

  directive_nest_checker #(.DEPTH_MAX(8), .LINE_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .in_last   (in_last),
    .err_valid (err_valid),
    .err_ready (err_ready),
    .err_code  (err_code),
    .err_line  (err_line),
    .depth     (depth),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Record every accepted error record.
  always @(posedge clk) begin
    if (rst_n && err_valid && err_ready) begin
      rec_code.push_back(err_code);
      rec_line.push_back(err_line);
    end
  end

  // Count done pulses.
  always @(posedge clk) begin
    if (rst_n && done) begin
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    in_char  = c;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input logic last);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i], last && (i == s.len() - 1));
    end
  endtask

  task automatic wait_done(input int base, input string tag);
    int n;
    n = 0;
    while (done_cnt == base && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic chk_rec(input string tag, input int idx, input int code, input int line);
    logic [2:0]  c;
    logic [15:0] l;
    c = 3'bxxx;
    l = 16'hxxxx;
    if (idx < rec_code.size()) begin
      c = rec_code[idx];
      l = rec_line[idx];
    end
    chk({tag, "_code"}, 32'(c), 32'(code));
    chk({tag, "_line"}, 32'(l), 32'(line));
  endtask

  initial begin
    int    eb;
    int    db;
    string sp;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    in_last   = 1'b0;
    err_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_err_code",  32'(err_code),  32'd0);
    chk("rst_err_line",  32'(err_line),  32'd0);
    chk("rst_depth",     32'(depth),     32'd0);
    chk("rst_done",      32'(done),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean file with a nested non-conditional directive
    eb = rec_code.size(); db = done_cnt;
    send_str("`ifdef ", 1'b0);
    chk("t1_depth_open", 32'(depth), 32'd1);
    send_str("A\n  `define X\n`endif\n", 1'b1);
    chk("t1_depth_close", 32'(depth), 32'd0);
    wait_done(db, "t1_done");
    chk("t1_errs", 32'(rec_code.size() - eb), 32'd0);
    repeat (5) @(negedge clk);
    chk("t1_done_once", 32'(done_cnt - db), 32'd1);
    chk("t1_ready_after", 32'(in_ready), 32'd1);

    // Conditionals sharing one line
    eb = rec_code.size(); db = done_cnt;
    send_str("x `ifdef F a `else b `endif\n", 1'b1);
    chk("t2_depth", 32'(depth), 32'd0);
    wait_done(db, "t2_done");
    chk("t2_errs", 32'(rec_code.size() - eb), 32'd2);
    chk_rec("t2_rec0", eb, 2, 1);
    chk_rec("t2_rec1", eb + 1, 2, 1);

    // Missing indentation on inner directives
    eb = rec_code.size(); db = done_cnt;
    send_str("`ifdef A\n`ifdef B\n`endif\n`endif\n", 1'b1);
    chk("t3_depth", 32'(depth), 32'd0);
    wait_done(db, "t3_done");
    chk("t3_errs", 32'(rec_code.size() - eb), 32'd2);
    chk_rec("t3_rec0", eb, 1, 2);
    chk_rec("t3_rec1", eb + 1, 1, 3);

    // Underflow
    eb = rec_code.size(); db = done_cnt;
    send_str("`endif\n", 1'b1);
    chk("t4a_depth", 32'(depth), 32'd0);
    wait_done(db, "t4a_done");
    chk("t4a_errs", 32'(rec_code.size() - eb), 32'd1);
    chk_rec("t4a_rec0", eb, 3, 1);

    // Unclosed at end of file
    eb = rec_code.size(); db = done_cnt;
    send_str("`ifdef A\n", 1'b1);
    chk("t4b_depth", 32'(depth), 32'd1);
    wait_done(db, "t4b_done");
    chk("t4b_errs", 32'(rec_code.size() - eb), 32'd1);
    chk_rec("t4b_rec0", eb, 5, 2);
    chk("t4b_depth_after", 32'(depth), 32'd0);

    // Overflow with back-pressure on the error record
    eb = rec_code.size(); db = done_cnt;
    sp = "";
    for (int k = 1; k <= 8; k++) begin
      send_str({sp, "`ifdef A\n"}, 1'b0);
      sp = {sp, "  "};
    end
    chk("t5_depth8", 32'(depth), 32'd8);
    err_ready = 1'b0;
    send_str({sp, "`ifdef "}, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_stall_ready", 32'(in_ready),  32'd0);
      chk("t5_stall_valid", 32'(err_valid), 32'd1);
      chk("t5_stall_code",  32'(err_code),  32'd4);
      chk("t5_stall_line",  32'(err_line),  32'd9);
      chk("t5_stall_depth", 32'(depth),     32'd8);
    end
    err_ready = 1'b1;
    send_str("A\n", 1'b1);
    wait_done(db, "t5_done");
    chk("t5_errs", 32'(rec_code.size() - eb), 32'd2);
    chk_rec("t5_rec0", eb, 4, 9);
    chk_rec("t5_rec1", eb + 1, 5, 10);

    // Over-long name is not a keyword
    eb = rec_code.size(); db = done_cnt;
    send_str("`ifndefz\n", 1'b1);
    chk("t7_depth", 32'(depth), 32'd0);
    wait_done(db, "t7_done");
    chk("t7_errs", 32'(rec_code.size() - eb), 32'd0);

    // Reset mid-keyword discards line and depth
    send_str("`ifdef A\n`ifd", 1'b0);
    chk("t6_depth_pre", 32'(depth), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_depth", 32'(depth),     32'd0);
    chk("t6_rst_ready", 32'(in_ready),  32'd1);
    chk("t6_rst_valid", 32'(err_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    eb = rec_code.size(); db = done_cnt;
    send_str("`endif\n", 1'b1);
    wait_done(db, "t6_done");
    chk("t6_errs", 32'(rec_code.size() - eb), 32'd1);
    chk_rec("t6_rec0", eb, 3, 1);
    chk("t6_depth", 32'(depth), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/directive_nest_checker.md
DIRECTIVE_NEST_CHECKER -- requirements
Module: directive_nest_checker

Interface
REQ-001 Parameter DEPTH_MAX, default 8: maximum conditional-directive nesting depth tracked.
REQ-002 Parameter LINE_W, default 16: width of the line counter and err_line.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  in_char valid.
REQ-006 in_ready  output  1  checker accepts in_char this cycle.
REQ-007 in_char  input  8  ASCII source character.
REQ-008 in_last  input  1  qualifies the final character of the file.
REQ-009 err_valid  output  1  error record pending.
REQ-010 err_ready  input  1  consumer accepts error record.
REQ-011 err_code  output  3  1=INDENT, 2=SAMELINE, 3=UNDERFLOW, 4=OVERFLOW, 5=UNCLOSED.
REQ-012 err_line  output  LINE_W  1-based line number of the offending directive.
REQ-013 depth  output  $clog2(DEPTH_MAX+1)  current nesting depth.
REQ-014 done  output  1  one-cycle pulse after the file is fully checked.

Function
REQ-015 Character transfer occurs on in_valid && in_ready; in_ready = !(err_valid && !err_ready) && state != FLUSH.
REQ-016 FSM states: LSTART (counting leading spaces), BODY, KEYWORD (collecting directive name after backtick 0x60), FLUSH (end-of-file check).
REQ-017 LSTART: space (0x20) increments indent count; backtick enters KEYWORD with at_start=1; newline stays in LSTART with indent cleared; any other character enters BODY.
REQ-018 BODY: backtick enters KEYWORD with at_start=0; newline enters LSTART and clears indent and the per-line conditional flag.
REQ-019 KEYWORD collects up to 6 identifier characters [A-Za-z0-9_]; the first non-identifier character terminates it and is then processed as in BODY (newline handling included).
REQ-020 Recognized keywords: ifdef, ifndef, elsif, else, endif; all other names are ignored but still count as a non-space line token.
REQ-021 Expected indent: 2*depth for ifdef/ifndef; 2*(depth-1) for elsif/else/endif.
REQ-022 INDENT error: a conditional directive with at_start=1 whose indent differs from expected.
REQ-023 SAMELINE error: a conditional directive on a line that already contained a conditional directive.
REQ-024 UNDERFLOW error: elsif/else/endif at depth 0; depth stays 0.
REQ-025 OVERFLOW error: ifdef/ifndef at depth DEPTH_MAX; depth saturates.
REQ-026 Depth: +1 on ifdef/ifndef, -1 on endif, unchanged on else/elsif; updated in the cycle the keyword terminates.
REQ-027 Only one error per directive; priority UNDERFLOW > OVERFLOW > SAMELINE > INDENT.
REQ-028 Error record is registered: err_valid rises the cycle after the terminating character and holds err_code and err_line stable until err_ready.
REQ-029 Line counter resets to 1, increments on each newline, and saturates at all-ones.
REQ-030 in_last terminates any open keyword and enters FLUSH; in FLUSH, depth != 0 raises UNCLOSED with err_line = final line; done pulses once after any pending error is accepted; then all state returns to reset values.
REQ-031 Input stalls while an error record is pending, so no error is ever lost or overwritten.

Reset
REQ-032 On rst_n low: state=LSTART, indent=0, depth=0, line=1, err_valid=0, err_code=0, err_line=0, done=0, in_ready=1, keyword buffer cleared.
REQ-033 Reset mid-file or mid-keyword discards all partial state; the next accepted character is treated as line 1, column 0.

Structure
REQ-034 Shared package directive_chk_pkg holds the err_code enum, the FSM state enum and the keyword ASCII constants.
REQ-035 Sub-module directive_kw_match maps the 6-character buffer and its length to the keyword enum; all sequencing stays in directive_nest_checker.

Verification
REQ-036 "`ifdef A\n  `define X\n`endif\n", in_last on final \n -> no errors, depth 1 then 0, done pulses once.
REQ-037 "x `ifdef F a `else b `endif\n" -> two SAMELINE errors, both err_line=1; depth ends at 0.
REQ-038 "`ifdef A\n`ifdef B\n`endif\n`endif\n" -> INDENT on line 2 and line 3.
REQ-039 "`endif\n" -> UNDERFLOW, line 1, depth stays 0; "`ifdef A\n" at end of file -> UNCLOSED, line 2.
REQ-040 Nine nested correctly-indented ifdefs -> OVERFLOW on line 9, depth=8; err_ready held low 5 cycles -> in_ready low, err_code and err_line stable throughout.
REQ-041 rst_n pulsed mid-keyword, then "`endif\n" -> UNDERFLOW reported with err_line=1.
